// File: rtl/matrix_store.sv
// matrix_store: circular bank of SLOTS matrix entries written by the UART matrix parser.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   wr_valid_i     one-cycle write strobe from the parser (input_done)
//   wr_error_i     parser error code, 3'b000 means the matrix is good
//   wr_m_i/wr_n_i  row/column count of the incoming matrix
//   wr_data_i      flattened elements, (r,c) at [ELEM_W*(DIM*r+c) +: ELEM_W]
//   clr_i          one-cycle pulse: invalidate every slot, rewind the write pointer
//   rd_req_i       one-cycle read request for slot rd_slot_i
//   rd_valid_o     one-cycle response strobe, one cycle after rd_req_i
//   rd_err_o       response refers to an empty slot (m/n/data forced to 0)
//   rd_m_o/rd_n_o  stored dimensions; held until the next response
//   rd_data_o      stored elements, same packing as wr_data_i
//   st_ok_o        one-cycle pulse: write accepted
//   st_rej_o       one-cycle pulse: write rejected
//   st_slot_o      slot written by the most recent accepted write
//   count_o        number of valid slots, 0..SLOTS
module matrix_store #(
    parameter int unsigned SLOTS  = 4,
    parameter int unsigned DIM    = 5,
    parameter int unsigned ELEM_W = 4,
    localparam int unsigned SW = $clog2(SLOTS),
    localparam int unsigned CW = $clog2(SLOTS + 1),
    localparam int unsigned AW = DIM * DIM * ELEM_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid_i,
    input  logic [2:0]    wr_error_i,
    input  logic [3:0]    wr_m_i,
    input  logic [3:0]    wr_n_i,
    input  logic [AW-1:0] wr_data_i,
    input  logic          clr_i,
    input  logic          rd_req_i,
    input  logic [SW-1:0] rd_slot_i,
    output logic          rd_valid_o,
    output logic          rd_err_o,
    output logic [3:0]    rd_m_o,
    output logic [3:0]    rd_n_o,
    output logic [AW-1:0] rd_data_o,
    output logic          st_ok_o,
    output logic          st_rej_o,
    output logic [SW-1:0] st_slot_o,
    output logic [CW-1:0] count_o
);

    localparam logic [3:0]    DimMax  = 4'(DIM);
    localparam logic [CW-1:0] CntFull = CW'(SLOTS);

    logic [3:0]    slot_m_q    [SLOTS];
    logic [3:0]    slot_n_q    [SLOTS];
    logic [AW-1:0] slot_data_q [SLOTS];
    logic [SLOTS-1:0] slot_vld_q;
    logic [SW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    logic          rd_valid_q;
    logic          rd_err_q;
    logic [3:0]    rd_m_q;
    logic [3:0]    rd_n_q;
    logic [AW-1:0] rd_data_q;
    logic          st_ok_q;
    logic          st_rej_q;
    logic [SW-1:0] st_slot_q;

    logic          wr_accept;
    logic [AW-1:0] wr_data_masked;

    always_comb begin
        wr_accept = (wr_error_i == 3'b000) &&
                    (wr_m_i != 4'd0) && (wr_m_i <= DimMax) &&
                    (wr_n_i != 4'd0) && (wr_n_i <= DimMax);
        // Elements outside the m x n window are stored as zero so readers never see parser junk.
        wr_data_masked = '0;
        for (int unsigned r = 0; r < DIM; r++) begin
            for (int unsigned c = 0; c < DIM; c++) begin
                if (r < 32'(wr_m_i) && c < 32'(wr_n_i)) begin
                    wr_data_masked[ELEM_W*(DIM*r+c) +: ELEM_W] =
                        wr_data_i[ELEM_W*(DIM*r+c) +: ELEM_W];
                end
            end
        end
    end

    // Reads sample the slot arrays before this edge's write/clear lands (nonblocking),
    // giving read-before-write and pre-clear semantics on a shared edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SLOTS; i++) begin
                slot_m_q[i]    <= '0;
                slot_n_q[i]    <= '0;
                slot_data_q[i] <= '0;
            end
            slot_vld_q <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_m_q     <= '0;
            rd_n_q     <= '0;
            rd_data_q  <= '0;
            st_ok_q    <= 1'b0;
            st_rej_q   <= 1'b0;
            st_slot_q  <= '0;
        end else begin
            rd_valid_q <= rd_req_i;
            st_ok_q    <= 1'b0;
            st_rej_q   <= 1'b0;

            if (rd_req_i) begin
                if (slot_vld_q[rd_slot_i]) begin
                    rd_err_q  <= 1'b0;
                    rd_m_q    <= slot_m_q[rd_slot_i];
                    rd_n_q    <= slot_n_q[rd_slot_i];
                    rd_data_q <= slot_data_q[rd_slot_i];
                end else begin
                    rd_err_q  <= 1'b1;
                    rd_m_q    <= '0;
                    rd_n_q    <= '0;
                    rd_data_q <= '0;
                end
            end

            if (clr_i) begin
                // A write on the clear edge is dropped silently.
                slot_vld_q <= '0;
                count_q    <= '0;
                wr_ptr_q   <= '0;
            end else if (wr_valid_i) begin
                if (wr_accept) begin
                    slot_m_q[wr_ptr_q]    <= wr_m_i;
                    slot_n_q[wr_ptr_q]    <= wr_n_i;
                    slot_data_q[wr_ptr_q] <= wr_data_masked;
                    slot_vld_q[wr_ptr_q]  <= 1'b1;
                    st_slot_q             <= wr_ptr_q;
                    // SLOTS is a power of two, so the pointer wraps to the oldest entry.
                    wr_ptr_q              <= wr_ptr_q + 1'b1;
                    if (count_q != CntFull) begin
                        count_q <= count_q + 1'b1;
                    end
                    st_ok_q <= 1'b1;
                end else begin
                    st_rej_q <= 1'b1;
                end
            end
        end
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign rd_m_o     = rd_m_q;
    assign rd_n_o     = rd_n_q;
    assign rd_data_o  = rd_data_q;
    assign st_ok_o    = st_ok_q;
    assign st_rej_o   = st_rej_q;
    assign st_slot_o  = st_slot_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_matrix_store.sv
// tb_matrix_store: table-driven and hand-written sequences; read responses are checked by a
// negedge monitor against a scoreboard queue filled from a reference model of the bank.
module tb_matrix_store;

    localparam int SLOTS  = 4;
    localparam int DIM    = 5;
    localparam int ELEM_W = 4;
    localparam int SW     = 2;
    localparam int CW     = 3;
    localparam int AW     = DIM * DIM * ELEM_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid_i = 1'b0;
    logic [2:0]    wr_error_i = '0;
    logic [3:0]    wr_m_i = '0;
    logic [3:0]    wr_n_i = '0;
    logic [AW-1:0] wr_data_i = '0;
    logic          clr_i = 1'b0;
    logic          rd_req_i = 1'b0;
    logic [SW-1:0] rd_slot_i = '0;
    logic          rd_valid_o;
    logic          rd_err_o;
    logic [3:0]    rd_m_o;
    logic [3:0]    rd_n_o;
    logic [AW-1:0] rd_data_o;
    logic          st_ok_o;
    logic          st_rej_o;
    logic [SW-1:0] st_slot_o;
    logic [CW-1:0] count_o;

    always #5 clk = ~clk;

    matrix_store #(.SLOTS(SLOTS), .DIM(DIM), .ELEM_W(ELEM_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid_i (wr_valid_i),
        .wr_error_i (wr_error_i),
        .wr_m_i     (wr_m_i),
        .wr_n_i     (wr_n_i),
        .wr_data_i  (wr_data_i),
        .clr_i      (clr_i),
        .rd_req_i   (rd_req_i),
        .rd_slot_i  (rd_slot_i),
        .rd_valid_o (rd_valid_o),
        .rd_err_o   (rd_err_o),
        .rd_m_o     (rd_m_o),
        .rd_n_o     (rd_n_o),
        .rd_data_o  (rd_data_o),
        .st_ok_o    (st_ok_o),
        .st_rej_o   (st_rej_o),
        .st_slot_o  (st_slot_o),
        .count_o    (count_o)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic          err;
        logic [3:0]    m;
        logic [3:0]    n;
        logic [AW-1:0] data;
    } rd_exp_t;

    typedef struct {
        logic [2:0] err;
        logic [3:0] m;
        logic [3:0] n;
        logic       ok;
    } vec_t;

    rd_exp_t rd_q[$];
    rd_exp_t mon_e;

    // Reference model of the bank
    logic [3:0]       mdl_m [SLOTS];
    logic [3:0]       mdl_n [SLOTS];
    logic [AW-1:0]    mdl_d [SLOTS];
    logic [SLOTS-1:0] mdl_vld;
    int               mdl_ptr;
    int               mdl_cnt;
    int               mdl_last;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] mask(input logic [AW-1:0] d, input logic [3:0] m,
                                            input logic [3:0] n);
        logic [AW-1:0] o;
        o = '0;
        for (int k = 0; k < DIM * DIM; k++) begin
            if ((k / DIM) < int'(m) && (k % DIM) < int'(n)) o[k*ELEM_W +: ELEM_W] = d[k*ELEM_W +: ELEM_W];
        end
        return o;
    endfunction

    // (r,c) = r*n+c+1 inside the window, 4'hF junk outside (must be masked away)
    function automatic logic [AW-1:0] mk_seq(input int m, input int n);
        logic [AW-1:0] o;
        o = '0;
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                o[ELEM_W*(DIM*r+c) +: ELEM_W] = (r < m && c < n) ? 4'(r * n + c + 1) : 4'hF;
            end
        end
        return o;
    endfunction

    function automatic logic [AW-1:0] rnd_data();
        return AW'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < SLOTS; i++) begin
            mdl_m[i] = '0;
            mdl_n[i] = '0;
            mdl_d[i] = '0;
        end
        mdl_vld  = '0;
        mdl_ptr  = 0;
        mdl_cnt  = 0;
        mdl_last = 0;
    endtask

    // Apply the currently driven inputs for one edge, update the model, check status outputs.
    task automatic cycle();
        rd_exp_t e;
        logic    acc;
        logic    ok_e;
        logic    rej_e;
        e = '{1'b0, 4'd0, 4'd0, '0};
        if (rd_req_i) begin
            e.err  = !mdl_vld[rd_slot_i];
            e.m    = e.err ? 4'd0 : mdl_m[rd_slot_i];
            e.n    = e.err ? 4'd0 : mdl_n[rd_slot_i];
            e.data = e.err ? '0 : mdl_d[rd_slot_i];
        end
        acc = (wr_error_i == 3'd0) && (wr_m_i >= 4'd1) && (wr_m_i <= 4'd5) &&
              (wr_n_i >= 4'd1) && (wr_n_i <= 4'd5);
        ok_e  = 1'b0;
        rej_e = 1'b0;
        if (clr_i) begin
            mdl_vld = '0;
            mdl_cnt = 0;
            mdl_ptr = 0;
        end else if (wr_valid_i) begin
            if (acc) begin
                mdl_m[mdl_ptr]   = wr_m_i;
                mdl_n[mdl_ptr]   = wr_n_i;
                mdl_d[mdl_ptr]   = mask(wr_data_i, wr_m_i, wr_n_i);
                mdl_vld[mdl_ptr] = 1'b1;
                mdl_last = mdl_ptr;
                mdl_ptr  = (mdl_ptr + 1) % SLOTS;
                if (mdl_cnt < SLOTS) mdl_cnt++;
                ok_e = 1'b1;
            end else begin
                rej_e = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (rd_req_i) rd_q.push_back(e);
        wr_valid_i = 1'b0;
        clr_i      = 1'b0;
        rd_req_i   = 1'b0;
        chk("st_ok", AW'(st_ok_o), AW'(ok_e));
        chk("st_rej", AW'(st_rej_o), AW'(rej_e));
        chk("count", AW'(count_o), AW'(mdl_cnt));
        chk("st_slot", AW'(st_slot_o), AW'(mdl_last));
    endtask

    task automatic wr(input logic [2:0] err, input logic [3:0] m, input logic [3:0] n,
                      input logic [AW-1:0] d);
        wr_valid_i = 1'b1;
        wr_error_i = err;
        wr_m_i     = m;
        wr_n_i     = n;
        wr_data_i  = d;
        cycle();
    endtask

    task automatic rd(input int slot);
        rd_req_i  = 1'b1;
        rd_slot_i = SW'(slot);
        cycle();
    endtask

    // Response monitor: a response must appear exactly one cycle after each request.
    always @(negedge clk) begin
        if (rd_q.size() != 0) begin
            mon_e = rd_q.pop_front();
            if (!rd_valid_o) begin
                checks++;
                failures++;
                $display("FAIL rd_latency: rd_valid got 0 expected 1");
            end else begin
                chk("rd_err", AW'(rd_err_o), AW'(mon_e.err));
                chk("rd_m", AW'(rd_m_o), AW'(mon_e.m));
                chk("rd_n", AW'(rd_n_o), AW'(mon_e.n));
                chk("rd_data", rd_data_o, mon_e.data);
            end
        end else if (rd_valid_o) begin
            checks++;
            failures++;
            $display("FAIL rd_spurious: rd_valid got 1 expected 0");
        end
    end

    vec_t          vecs[9];
    logic [AW-1:0] hist [5];
    logic [AW-1:0] dnew;

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_valid"}, AW'(rd_valid_o), '0);
        chk({tag, "_rd_err"}, AW'(rd_err_o), '0);
        chk({tag, "_rd_m"}, AW'(rd_m_o), '0);
        chk({tag, "_rd_n"}, AW'(rd_n_o), '0);
        chk({tag, "_rd_data"}, rd_data_o, '0);
        chk({tag, "_st_ok"}, AW'(st_ok_o), '0);
        chk({tag, "_st_rej"}, AW'(st_rej_o), '0);
        chk({tag, "_st_slot"}, AW'(st_slot_o), '0);
        chk({tag, "_count"}, AW'(count_o), '0);
    endtask

    initial begin
        vecs[0] = '{3'd0, 4'd2, 4'd3, 1'b1};
        vecs[1] = '{3'd0, 4'd6, 4'd3, 1'b0};
        vecs[2] = '{3'd3, 4'd2, 4'd2, 1'b0};
        vecs[3] = '{3'd0, 4'd0, 4'd1, 1'b0};
        vecs[4] = '{3'd0, 4'd5, 4'd5, 1'b1};
        vecs[5] = '{3'd0, 4'd1, 4'd0, 1'b0};
        vecs[6] = '{3'd1, 4'd1, 4'd1, 1'b0};
        vecs[7] = '{3'd0, 4'd5, 4'd6, 1'b0};
        vecs[8] = '{3'd0, 4'd1, 4'd1, 1'b1};
        mdl_reset();

        // Reset state
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 2x3 {1..6}, junk outside the window
        wr(3'd0, 4'd2, 4'd3, mk_seq(2, 3));
        chk("t1_st_slot", AW'(st_slot_o), AW'(0));
        chk("t1_count", AW'(count_o), AW'(1));
        rd(0);
        chk("t1_rd_valid", AW'(rd_valid_o), AW'(1));
        chk("t1_rd_m", AW'(rd_m_o), AW'(2));
        chk("t1_rd_n", AW'(rd_n_o), AW'(3));
        chk("t1_e12", AW'(rd_data_o[ELEM_W*(DIM*1+2) +: ELEM_W]), AW'(6));
        chk("t1_e20", AW'(rd_data_o[ELEM_W*(DIM*2+0) +: ELEM_W]), AW'(0));
        chk("t1_e00", AW'(rd_data_o[0 +: ELEM_W]), AW'(1));
        cycle();
        chk("t1_hold_valid", AW'(rd_valid_o), AW'(0));
        chk("t1_hold_m", AW'(rd_m_o), AW'(2));

        // Rejections and empty-slot read
        wr(3'd0, 4'd6, 4'd2, rnd_data());
        wr(3'b011, 4'd2, 4'd2, rnd_data());
        chk("t2_count", AW'(count_o), AW'(1));
        rd(1);
        chk("t2_rd_err", AW'(rd_err_o), AW'(1));
        chk("t2_rd_data", rd_data_o, '0);

        // Five full writes wrap into slot 0
        clr_i = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            hist[i] = rnd_data();
            wr(3'd0, 4'd5, 4'd5, hist[i]);
            chk($sformatf("t3_st_slot%0d", i), AW'(st_slot_o), AW'(i % 4));
        end
        chk("t3_count", AW'(count_o), AW'(4));
        rd(0);
        chk("t3_slot0", rd_data_o, hist[4]);
        rd(1);
        chk("t3_slot1", rd_data_o, hist[1]);

        // Read and write of slot 1 on the same edge
        dnew = rnd_data();
        rd_req_i  = 1'b1;
        rd_slot_i = 2'd1;
        wr(3'd0, 4'd5, 4'd5, dnew);
        chk("t4_old", rd_data_o, hist[1]);
        rd(1);
        chk("t4_new", rd_data_o, dnew);

        // Clear wins over a concurrent good write
        clr_i = 1'b1;
        wr(3'd0, 4'd3, 4'd3, rnd_data());
        chk("t5_no_ok", AW'(st_ok_o), AW'(0));
        chk("t5_count", AW'(count_o), AW'(0));
        for (int s = 0; s < SLOTS; s++) begin
            rd(s);
            chk($sformatf("t5_err%0d", s), AW'(rd_err_o), AW'(1));
        end
        wr(3'd0, 4'd4, 4'd2, rnd_data());
        chk("t5_slot0", AW'(st_slot_o), AW'(0));
        rd(0);

        // Table of acceptance cases, back-to-back where accepted writes are read back
        for (int i = 0; i < 9; i++) begin
            wr(vecs[i].err, vecs[i].m, vecs[i].n, rnd_data());
            chk($sformatf("vec%0d_ok", i), AW'(st_ok_o), AW'(vecs[i].ok));
            chk($sformatf("vec%0d_rej", i), AW'(st_rej_o), AW'(!vecs[i].ok));
            if (vecs[i].ok) rd(mdl_last);
        end

        // Reset between a read request and its response, with a st_ok pending too
        rd_req_i   = 1'b1;
        rd_slot_i  = 2'd0;
        wr_valid_i = 1'b1;
        wr_error_i = 3'd0;
        wr_m_i     = 4'd2;
        wr_n_i     = 4'd2;
        wr_data_i  = rnd_data();
        @(posedge clk);
        #1;
        rd_req_i   = 1'b0;
        wr_valid_i = 1'b0;
        rst_n      = 1'b0;
        rd_q.delete();
        mdl_reset();
        @(negedge clk);
        chk_all_zero("t6");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(0);
        chk("t6_rd_err", AW'(rd_err_o), AW'(1));
        cycle();

        chk("sb_drained", AW'(rd_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
